int_to_fp_arbiter: RTL and testbench

//  Shares one combinational int_to_fp (int32 -> bf16) converter between NUM_REQ requesters.

---
 rtl/fpu_pkg.sv | 8 +
 rtl/i2f_rr_arb.sv | 25 ++
 rtl/int_to_fp.sv | 25 ++
 rtl/int_to_fp_arbiter.sv | 67 ++++++
 tb/tb_int_to_fp_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the int32 -> bf16 conversion path.
package fpu_pkg;
  typedef struct packed {
    logic [31:0] data;
    logic        is_unsigned;
  } i2f_req_t;
  localparam logic [15:0] BF16_ZERO = 16'h0000;
endpackage

// File: rtl/i2f_rr_arb.sv
// i2f_rr_arb: round-robin picker, first requester at or after rr (wrapping).
module i2f_rr_arb #(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    id
);
  logic [ID_W-1:0] j;
  // Scanning from farthest to nearest lets the closest requester win by overwrite.
  always_comb begin
    gnt = '0;
    id = '0;
    j = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = ID_W'((int'(rr) + i) % NUM_REQ);
      if (req[j]) begin
        gnt = NUM_REQ'(1) << j;
        id = j;
      end
    end
  end
endmodule

// File: rtl/int_to_fp.sv
// int_to_fp: combinational int32 (signed or unsigned) to bf16, round to nearest even.
module int_to_fp
  import fpu_pkg::*;
(
  input  i2f_req_t    req,
  output logic [15:0] res
);
  logic        neg;
  logic [31:0] mag;
  logic [31:0] norm;
  logic [4:0]  msb;
  logic        rnd;
  logic [14:0] em;
  // A mantissa carry out of rounding ripples into the exponent field for free.
  always_comb begin
    neg = !req.is_unsigned & req.data[31];
    mag = neg ? -req.data : req.data;
    msb = '0;
    for (int i = 0; i < 32; i++) if (mag[i]) msb = 5'(i);
    norm = mag << (5'd31 - msb);
    rnd = norm[23] & (norm[24] | |norm[22:0]);
    em = {8'(msb) + 8'd127, norm[30:24]} + 15'(rnd);
    res = (mag == '0) ? BF16_ZERO : {neg, em};
  end
endmodule

// File: rtl/int_to_fp_arbiter.sv
// int_to_fp_arbiter: round-robin share of one int_to_fp converter, 2-stage valid/ready pipeline.
module int_to_fp_arbiter
  import fpu_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*32-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]    req_unsigned_i,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  input  logic [NUM_REQ-1:0]    rsp_ready_i,
  output logic [15:0]           rsp_data_o,
  input  logic                  flush_i,
  output logic                  busy_o
);
  i2f_req_t           op_q;
  logic [ID_W-1:0]    id1_q, id2_q, rr_q, gnt_id;
  logic               s1_valid, s2_valid;
  logic [15:0]        res_q, conv;
  logic [NUM_REQ-1:0] gnt;
  logic               s1_adv, s2_adv, grant_en, any_gnt;

  i2f_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (.req(req_valid_i), .rr(rr_q), .gnt(gnt), .id(gnt_id));
  int_to_fp u_cvt (.req(op_q), .res(conv));

  assign s2_adv      = !s2_valid | rsp_ready_i[id2_q];
  assign s1_adv      = !s1_valid | s2_adv;
  // Reset also masks the combinational grant so ready drops without a clock.
  assign grant_en    = s1_adv & !flush_i & !rst_i;
  assign req_ready_o = grant_en ? gnt : '0;
  assign any_gnt     = grant_en & |req_valid_i;
  assign rsp_valid_o = s2_valid ? (NUM_REQ'(1) << id2_q) : '0;
  assign rsp_data_o  = res_q;
  assign busy_o      = s1_valid | s2_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q <= '0;
      id1_q <= '0;
      id2_q <= '0;
      rr_q <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      res_q <= BF16_ZERO;
    end else begin
      if (s1_adv) s1_valid <= any_gnt;
      if (any_gnt) begin
        op_q <= '{data: req_data_i[32*gnt_id +: 32], is_unsigned: req_unsigned_i[gnt_id]};
        id1_q <= gnt_id;
        rr_q <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
      if (s2_adv) begin
        res_q <= conv;
        id2_q <= id1_q;
        s2_valid <= s1_valid;
      end
      if (flush_i) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_int_to_fp_arbiter.sv
// tb_int_to_fp_arbiter: directed scenarios plus a randomized run against a queue-based reference.
module tb_int_to_fp_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_uns, rsp_valid, rsp_ready;
  logic [63:0] req_data;
  logic [15:0] rsp_data;
  logic        flush, busy;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    int          id;
    logic [15:0] res;
    int          stage;
  } entry_t;

  int_to_fp_arbiter #(.NUM_REQ(2)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_data_i(req_data), .req_unsigned_i(req_uns), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .flush_i(flush), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Exact integer value rounded to 8 significant bits, ties to even.
  function automatic logic [15:0] ref_bf16(input logic [31:0] d, input logic uns);
    longint m, q, r, dv;
    logic   neg;
    int     e;
    neg = !uns && d[31];
    m = uns ? longint'({32'b0, d}) : longint'($signed(d));
    if (m < 0) m = -m;
    if (m == 0) return 16'h0000;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    if (e <= 7) q = m * (longint'(1) << (7 - e));
    else begin
      dv = longint'(1) << (e - 7);
      q = m / dv;
      r = m % dv;
      if (2 * r > dv || (2 * r == dv && q % 2 == 1)) q++;
    end
    if (q == 256) begin
      q = 128;
      e++;
    end
    return {neg, 8'(e + 127), 7'(q - 128)};
  endfunction

  task automatic idle();
    req_valid = '0;
    req_data = '0;
    req_uns = '0;
    rsp_ready = '0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    total++; if (rsp_data !== 16'h0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0000", rsp_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 2'b01; req_data = 64'd1; req_uns = 2'b01; rsp_ready = 2'b01;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL t1_ready got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL t1_early_rsp got=%b exp=00", rsp_valid); end
    @(negedge clk);
    #1;
    total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL t1_rsp_valid got=%b exp=01", rsp_valid); end
    total++; if (rsp_data !== 16'h3F80) begin bad++; $display("FAIL t1_rsp_data got=%h exp=3f80", rsp_data); end
    @(negedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_drain_busy got=%b exp=0", busy); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g;
    logic [15:0] exp_d;
    do_reset();
    req_valid = 2'b11; req_data = {32'd256, 32'd3}; req_uns = 2'b00; rsp_ready = 2'b11;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
      total++; if (req_ready !== exp_g) begin bad++; $display("FAIL t2_grant c=%0d got=%b exp=%b", c, req_ready, exp_g); end
      if (c >= 2) begin
        exp_d = (c % 2 == 0) ? 16'h4040 : 16'h4380;
        total++; if (rsp_valid !== exp_g || rsp_data !== exp_d)
          begin bad++; $display("FAIL t2_rsp c=%0d got=%b/%h exp=%b/%h", c, rsp_valid, rsp_data, exp_g, exp_d); end
      end
      @(negedge clk);
    end
    idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stall();
    do_reset();
    req_valid = 2'b01; req_data = {32'd0, 32'd256}; req_uns = 2'b00;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL t3_grant_a got=%b exp=01", req_ready); end
    @(negedge clk);
    req_data = {32'd0, 32'hFFFF_FFFE};
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL t3_grant_b got=%b exp=01", req_ready); end
    @(negedge clk);
    req_data = {32'd0, 32'd3};
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL t3_backpressure c=%0d got=%b exp=00", c, req_ready); end
      total++; if (rsp_valid !== 2'b01 || rsp_data !== 16'h4380)
        begin bad++; $display("FAIL t3_hold c=%0d got=%b/%h exp=01/4380", c, rsp_valid, rsp_data); end
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    #1;
    total++; if (req_ready !== 2'b01 || rsp_data !== 16'h4380)
      begin bad++; $display("FAIL t3_release got=%b/%h exp=01/4380", req_ready, rsp_data); end
    @(negedge clk);
    req_valid = '0;
    #1;
    total++; if (rsp_valid !== 2'b01 || rsp_data !== 16'hC000)
      begin bad++; $display("FAIL t3_second got=%b/%h exp=01/c000", rsp_valid, rsp_data); end
    @(negedge clk);
    #1;
    total++; if (rsp_valid !== 2'b01 || rsp_data !== 16'h4040)
      begin bad++; $display("FAIL t3_third got=%b/%h exp=01/4040", rsp_valid, rsp_data); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_corner();
    logic [31:0] vals[3] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0002};
    logic        unss[3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] exps[3] = '{16'h0000, 16'hBF80, 16'h4000};
    do_reset();
    rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      req_valid = 2'b10; req_data = {vals[i], 32'd0}; req_uns = {unss[i], 1'b0};
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      #1;
      total++; if (rsp_valid !== 2'b10 || rsp_data !== exps[i])
        begin bad++; $display("FAIL t4_corner i=%0d got=%b/%h exp=10/%h", i, rsp_valid, rsp_data, exps[i]); end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    req_valid = 2'b01; req_data = {32'd3, 32'd1}; req_uns = 2'b11;
    @(negedge clk);
    req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b11; flush = 1'b1;
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL t5_no_grant got=%b exp=00", req_ready); end
    total++; if (busy !== 1'b1 || rsp_valid !== 2'b01) begin bad++; $display("FAIL t5_full got=%b/%b exp=1/01", busy, rsp_valid); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    total++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL t5_flushed got=%b/%b exp=00/0", rsp_valid, busy); end
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL t5_rr_kept got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = '0; rsp_ready = 2'b11;
    @(negedge clk);
    #1;
    total++; if (rsp_valid !== 2'b01 || rsp_data !== 16'h3F80)
      begin bad++; $display("FAIL t5_after got=%b/%h exp=01/3f80", rsp_valid, rsp_data); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    req_valid = 2'b01; req_data = {32'd0, 32'd5}; req_uns = 2'b00;
    repeat (2) @(negedge clk);
    req_valid = 2'b11;
    #2 rst = 1'b1;
    #1;
    total++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00)
      begin bad++; $display("FAIL t6_handshake got=%b/%b exp=00/00", rsp_valid, req_ready); end
    total++; if (busy !== 1'b0 || rsp_data !== 16'h0)
      begin bad++; $display("FAIL t6_state got=%b/%h exp=0/0000", busy, rsp_data); end
    #3 rst = 1'b0;
    @(negedge clk);
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL t6_first_grant got=%b exp=01", req_ready); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_random();
    entry_t      q[$];
    logic        pend[2];
    logic [31:0] pdata[2];
    logic        puns[2];
    int          rr, k, eg;
    logic        vis, cons, stuck;
    logic [1:0]  exp_v, exp_g;
    do_reset();
    rr = 0;
    pend = '{1'b0, 1'b0};
    for (int c = 0; c < 600; c++) begin
      for (int r = 0; r < 2; r++) if (!pend[r] && $urandom_range(1, 0) == 1) begin
        pend[r] = 1'b1;
        puns[r] = 1'($urandom);
        case ($urandom_range(3, 0))
          0: pdata[r] = $urandom_range(300, 0);
          1: pdata[r] = -$urandom_range(300, 1);
          2: pdata[r] = $urandom;
          default: pdata[r] = (32'd1 << $urandom_range(31, 0)) + $urandom_range(2, 0) - 32'd1;
        endcase
      end
      req_valid = {pend[1], pend[0]};
      req_data = {pdata[1], pdata[0]};
      req_uns = {puns[1], puns[0]};
      rsp_ready = {1'($urandom_range(3, 0) != 0), 1'($urandom_range(3, 0) != 0)};
      flush = ($urandom_range(24, 0) == 0);
      #1;
      vis = q.size() > 0 && q[0].stage == 2;
      exp_v = vis ? 2'(1 << q[0].id) : 2'b00;
      total++; if (rsp_valid !== exp_v) begin bad++; $display("FAIL rnd_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, exp_v); end
      if (vis) begin
        total++; if (rsp_data !== q[0].res) begin bad++; $display("FAIL rnd_rsp_data c=%0d got=%h exp=%h", c, rsp_data, q[0].res); end
      end
      total++; if (busy !== (q.size() != 0)) begin bad++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, q.size() != 0); end
      cons = vis && rsp_ready[q[0].id];
      stuck = q.size() > 0 && q[q.size()-1].stage == 1 && vis && !cons;
      eg = -1;
      if (!stuck && !flush) for (int i = 1; i >= 0; i--) begin
        k = (rr + i) % 2;
        if (pend[k]) eg = k;
      end
      exp_g = (eg >= 0) ? 2'(1 << eg) : 2'b00;
      total++; if (req_ready !== exp_g) begin bad++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, req_ready, exp_g); end
      if (flush) q.delete();
      else begin
        if (cons) void'(q.pop_front());
        if (!stuck) foreach (q[i]) q[i].stage = 2;
        if (eg >= 0) begin
          q.push_back('{id: eg, res: ref_bf16(pdata[eg], puns[eg]), stage: 1});
          pend[eg] = 1'b0;
          rr = (eg + 1) % 2;
        end
      end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_corner();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
